mul_div_unit: RTL and testbench

- Iterative 64-bit unsigned multiply/divide unit in the EX stage of the 64-bit pipelined core.
- Consumes the RS/RT operand pair read from the register file.
- Returns a result plus destination address and write strobe toward writeback, so the result is written back into the register file.
- Radix-2 (one bit per cycle), fixed latency, start/busy/done handshake; the hazard unit stalls the pipeline while busy_o is high.

---
 rtl/mul_div_unit_if.sv | 27 ++
 rtl/mul_div_unit.sv | 123 ++++++++++++
 tb/tb_mul_div_unit.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the EX-stage issue logic and the iterative
// multiply/divide unit.
interface mul_div_unit_if #(
    parameter int WIDTH = 64
);
    logic             start_i;
    logic             flush_i;
    logic [1:0]       op_i;
    logic [WIDTH-1:0] rs_data_i;
    logic [WIDTH-1:0] rt_data_i;
    logic [4:0]       rd_addr_i;
    logic             busy_o;
    logic             done_o;
    logic             reg_write_o;
    logic [4:0]       rd_addr_o;
    logic [WIDTH-1:0] result_o;

    modport master (
        output start_i, flush_i, op_i, rs_data_i, rt_data_i, rd_addr_i,
        input  busy_o, done_o, reg_write_o, rd_addr_o, result_o
    );

    modport slave (
        input  start_i, flush_i, op_i, rs_data_i, rt_data_i, rd_addr_i,
        output busy_o, done_o, reg_write_o, rd_addr_o, result_o
    );
endinterface

// File: rtl/mul_div_unit.sv
// Radix-2 iterative unsigned MUL/MULHU/DIVU/REMU unit with a fixed
// WIDTH-iteration latency and a start/busy/done handshake.
module mul_div_unit #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 7
) (
    input logic          clk_i,
    input logic          rst_i,
    mul_div_unit_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [4:0]         rd_lat_q, rd_lat_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [4:0]         rd_addr_q, rd_addr_d;

    // Shift-add: {hi, lo} holds {partial product, remaining multiplier bits}.
    function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] p,
                                                    input logic [WIDTH-1:0]   m);
        logic [WIDTH:0] sum;
        sum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
        return {sum, p[WIDTH-1:1]};
    endfunction

    // Restoring divide: {hi, lo} holds {partial remainder, dividend/quotient}.
    // A zero divisor always "fits", giving an all-ones quotient and hi=dividend.
    function automatic logic [2*WIDTH-1:0] div_step(input logic [2*WIDTH-1:0] p,
                                                    input logic [WIDTH-1:0]   d);
        logic [WIDTH:0]   sh;
        logic [WIDTH-1:0] diff;
        sh   = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
        diff = sh[WIDTH-1:0] - d;
        if (sh >= {1'b0, d}) begin
            return {diff, p[WIDTH-2:0], 1'b1};
        end
        return {sh[WIDTH-1:0], p[WIDTH-2:0], 1'b0};
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        opnd_d    = opnd_q;
        prod_d    = prod_q;
        rd_lat_d  = rd_lat_q;
        result_d  = result_q;
        rd_addr_d = rd_addr_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start_i && !bus.flush_i) begin
                    state_d  = S_RUN;
                    op_d     = bus.op_i;
                    opnd_d   = bus.rt_data_i;
                    prod_d   = {{WIDTH{1'b0}}, bus.rs_data_i};
                    rd_lat_d = bus.rd_addr_i;
                    cnt_d    = '0;
                end
            end
            S_RUN: begin
                if (bus.flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    prod_d = op_q[1] ? div_step(prod_q, opnd_q) : mul_step(prod_q, opnd_q);
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_ITER) begin
                        state_d   = S_DONE;
                        // Odd opcodes (MULHU, REMU) take the upper half.
                        result_d  = op_q[0] ? prod_d[2*WIDTH-1:WIDTH] : prod_d[WIDTH-1:0];
                        rd_addr_d = rd_lat_q;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            result_q  <= '0;
            rd_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            rd_addr_q <= rd_addr_d;
        end
    end

    // Operand/datapath registers are only meaningful after an accepted start.
    always_ff @(posedge clk_i) begin
        op_q     <= op_d;
        opnd_q   <= opnd_d;
        prod_q   <= prod_d;
        rd_lat_q <= rd_lat_d;
    end

    assign bus.busy_o      = (state_q != S_IDLE);
    assign bus.done_o      = (state_q == S_DONE);
    assign bus.reg_write_o = (state_q == S_DONE);
    assign bus.rd_addr_o   = rd_addr_q;
    assign bus.result_o    = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed and randomized checks of mul_div_unit against an arithmetic
// reference model.
module tb_mul_div_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;
    logic [63:0] last_exp = '0;
    logic [4:0]  last_rd  = '0;

    mul_div_unit_if #(.WIDTH(64)) bus ();

    mul_div_unit #(.WIDTH(64), .CNT_W(7)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_model(input logic [1:0] op,
                                              input logic [63:0] a,
                                              input logic [63:0] b);
        logic [127:0] p;
        p = {64'd0, a} * {64'd0, b};
        case (op)
            2'd0:    return p[63:0];
            2'd1:    return p[127:64];
            2'd2:    return (b == 64'd0) ? {64{1'b1}} : a / b;
            default: return (b == 64'd0) ? a : a % b;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [4:0] rd);
        logic [63:0] exp;
        int cyc;
        exp = ref_model(op, a, b);
        bus.start_i   = 1'b1;
        bus.op_i      = op;
        bus.rs_data_i = a;
        bus.rt_data_i = b;
        bus.rd_addr_i = rd;
        tick();
        bus.start_i   = 1'b0;
        bus.op_i      = 2'($urandom_range(0, 3));
        bus.rs_data_i = {$urandom, $urandom};
        bus.rt_data_i = {$urandom, $urandom};
        bus.rd_addr_i = 5'($urandom);
        chk({tag, " busy_after_accept"}, 64'(bus.busy_o), 64'd1);
        cyc = 0;
        while (!bus.done_o && cyc < 200) begin
            tick();
            cyc++;
        end
        chk({tag, " latency"}, 64'(cyc), 64'd64);
        chk({tag, " result"}, bus.result_o, exp);
        chk({tag, " rd_addr"}, 64'(bus.rd_addr_o), 64'(rd));
        chk({tag, " reg_write"}, 64'(bus.reg_write_o), 64'd1);
        tick();
        chk({tag, " busy_after_done"}, 64'(bus.busy_o), 64'd0);
        chk({tag, " done_one_cycle"}, 64'(bus.done_o), 64'd0);
        chk({tag, " result_held"}, bus.result_o, exp);
        last_exp = exp;
        last_rd  = rd;
    endtask

    initial begin
        bit seen_done;
        bus.start_i   = 1'b0;
        bus.flush_i   = 1'b0;
        bus.op_i      = 2'd0;
        bus.rs_data_i = '0;
        bus.rt_data_i = '0;
        bus.rd_addr_i = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset busy", 64'(bus.busy_o), 64'd0);
        chk("reset done", 64'(bus.done_o), 64'd0);
        chk("reset reg_write", 64'(bus.reg_write_o), 64'd0);
        chk("reset result", bus.result_o, 64'd0);
        chk("reset rd_addr", 64'(bus.rd_addr_o), 64'd0);

        run_op("mul_3x5", 2'd0, 64'd3, 64'd5, 5'd7);
        run_op("mul_max_x2", 2'd0, {64{1'b1}}, 64'd2, 5'd1);
        run_op("mulhu_max_x2", 2'd1, {64{1'b1}}, 64'd2, 5'd2);
        run_op("mulhu_max_x_max", 2'd1, {64{1'b1}}, {64{1'b1}}, 5'd31);
        run_op("divu_100_7", 2'd2, 64'd100, 64'd7, 5'd3);
        run_op("remu_100_7", 2'd3, 64'd100, 64'd7, 5'd4);
        run_op("divu_5_9", 2'd2, 64'd5, 64'd9, 5'd5);
        run_op("remu_5_9", 2'd3, 64'd5, 64'd9, 5'd6);
        run_op("divu_42_0", 2'd2, 64'd42, 64'd0, 5'd8);
        run_op("remu_42_0", 2'd3, 64'd42, 64'd0, 5'd9);
        run_op("divu_max_1", 2'd2, {64{1'b1}}, 64'd1, 5'd10);

        // Start and flush together in IDLE: nothing is accepted.
        bus.start_i = 1'b1;
        bus.flush_i = 1'b1;
        bus.op_i    = 2'd0;
        tick();
        bus.start_i = 1'b0;
        bus.flush_i = 1'b0;
        chk("idle_flush busy", 64'(bus.busy_o), 64'd0);
        tick();
        chk("idle_flush no_done", 64'(bus.done_o), 64'd0);

        // Flush mid-run with an ignored start while busy.
        seen_done     = 1'b0;
        bus.start_i   = 1'b1;
        bus.op_i      = 2'd0;
        bus.rs_data_i = 64'd6;
        bus.rt_data_i = 64'd7;
        bus.rd_addr_i = 5'd12;
        tick();
        bus.start_i = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (bus.done_o) seen_done = 1'b1;
            if (k == 5) begin
                bus.start_i   = 1'b1;
                bus.op_i      = 2'd3;
                bus.rs_data_i = 64'd1000;
                bus.rt_data_i = 64'd3;
                bus.rd_addr_i = 5'd20;
            end
            if (k == 6) bus.start_i = 1'b0;
            if (k == 10) bus.flush_i = 1'b1;
        end
        tick();
        bus.flush_i = 1'b0;
        if (bus.done_o) seen_done = 1'b1;
        chk("flush busy", 64'(bus.busy_o), 64'd0);
        chk("flush no_done", 64'(seen_done), 64'd0);
        chk("flush result_kept", bus.result_o, last_exp);
        chk("flush rd_kept", 64'(bus.rd_addr_o), 64'(last_rd));
        run_op("mul_6x7_after_flush", 2'd0, 64'd6, 64'd7, 5'd12);

        // Reset in the middle of a divide.
        seen_done     = 1'b0;
        bus.start_i   = 1'b1;
        bus.op_i      = 2'd2;
        bus.rs_data_i = {$urandom, $urandom};
        bus.rt_data_i = 64'd13;
        bus.rd_addr_i = 5'd17;
        tick();
        bus.start_i = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (bus.done_o) seen_done = 1'b1;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst busy", 64'(bus.busy_o), 64'd0);
        chk("midrst done", 64'(bus.done_o), 64'd0);
        chk("midrst result", bus.result_o, 64'd0);
        chk("midrst rd_addr", 64'(bus.rd_addr_o), 64'd0);
        chk("midrst no_early_done", 64'(seen_done), 64'd0);
        run_op("divu_100_7_after_rst", 2'd2, 64'd100, 64'd7, 5'd3);

        for (int i = 0; i < 24; i++) begin
            logic [1:0]  op;
            logic [63:0] a;
            logic [63:0] b;
            op = 2'($urandom_range(0, 3));
            a  = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       b = 64'd0;
                1:       b = 64'($urandom_range(1, 1000));
                2:       b = 64'($urandom);
                default: b = {$urandom, $urandom};
            endcase
            run_op($sformatf("rand%0d_op%0d", i, op), op, a, b, 5'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
